// File: rtl/vslc_pkg.sv
// Shared scan-state encoding, the END opcode and default widths for the VSLC scan sequencer.
// Latency: none (types and constants only). Backpressure: none.
package vslc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    FETCH,
    EXEC,
    COMMIT
  } scan_state_t;

  localparam logic [7:0] OPC_END = 8'hFF;

  localparam int VSLC_ADDR_W     = 8;
  localparam int VSLC_INSTR_W    = 8;
  localparam int VSLC_WDT_CYCLES = 64;

endpackage

// File: rtl/vslc_fetch_watchdog.sv
// Fetch timeout detector: counts cycles spent in FETCH and flags the last one if no ack arrives.
// Latency: o_timeout is combinational on the WDT_CYCLES-th FETCH cycle. Backpressure: none, pure observer.
module vslc_fetch_watchdog #(
  parameter int WDT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(WDT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Every FETCH is entered from a non-FETCH state, so clearing while inactive
  // restarts the count on each new fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = i_active && !i_ack && (r_cnt == CNT_W'(WDT_CYCLES - 1));

endmodule

// File: rtl/vslc_scan_sequencer.sv
// VSLC scan-cycle controller: latch inputs, fetch/execute to prog_last or END, commit outputs (optional VSLC_SCAN_WATCHDOG_EN).
// Latency: 2N+2 cycles per scan with zero-wait fetches; FETCH stalls until fetch_ack (or watchdog timeout).
module vslc_scan_sequencer
  import vslc_pkg::*;
#(
  parameter int ADDR_W  = VSLC_ADDR_W,
  parameter int INSTR_W = VSLC_INSTR_W
`ifdef VSLC_SCAN_WATCHDOG_EN
  , parameter int WDT_CYCLES = VSLC_WDT_CYCLES
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_run,
  input  logic               i_step,
  input  logic [ADDR_W-1:0]  i_prog_last,
  output logic               o_fetch_req,
  output logic [ADDR_W-1:0]  o_fetch_addr,
  input  logic               i_fetch_ack,
  input  logic [INSTR_W-1:0] i_fetch_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_exec_en,
  output logic               o_in_latch,
  output logic               o_out_commit,
  output logic               o_addr_strobe,
  output logic               o_scan_cycle_clk,
  output logic               o_busy,
  output logic               o_fault
);

  scan_state_t        r_state;
  scan_state_t        w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_last_q;
  logic [INSTR_W-1:0] r_instr;
  logic               r_one_shot;
  logic               r_fetch_req;
  logic               r_exec_en;
  logic               r_in_latch;
  logic               r_out_commit;
  logic               r_addr_strobe;
  logic               r_scan_clk;
  logic               r_busy;
  logic               w_timeout;
  logic               w_fault;
  logic               w_is_end;

  assign w_is_end = (i_fetch_data == INSTR_W'(OPC_END));

`ifdef VSLC_SCAN_WATCHDOG_EN
  logic r_fault;

  vslc_fetch_watchdog #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_fetch_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_active  (r_state == FETCH),
    .i_ack     (i_fetch_ack),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_timeout) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_timeout = 1'b0;
  assign w_fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if ((i_run || i_step) && !w_fault) begin
          w_next = LATCH;
        end
      end
      LATCH: w_next = FETCH;
      FETCH: begin
        // A late ack still wins over a timeout in the same cycle.
        if (i_fetch_ack) begin
          w_next = w_is_end ? COMMIT : EXEC;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      EXEC:    w_next = (r_pc == r_last_q) ? COMMIT : FETCH;
      COMMIT:  w_next = (i_run && !r_one_shot) ? LATCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_last_q   <= '0;
      r_instr    <= '0;
      r_one_shot <= 1'b0;
    end else begin
      if (r_state == IDLE && w_next == LATCH) begin
        r_one_shot <= i_step && !i_run;
      end else if (w_next == IDLE) begin
        r_one_shot <= 1'b0;
      end
      if (r_state == LATCH) begin
        r_pc     <= '0;
        r_last_q <= i_prog_last;
      end else if (r_state == EXEC && r_pc != r_last_q) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      if (r_state == FETCH && i_fetch_ack) begin
        r_instr <= i_fetch_data;
      end
    end
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_req   <= 1'b0;
      r_exec_en     <= 1'b0;
      r_in_latch    <= 1'b0;
      r_out_commit  <= 1'b0;
      r_addr_strobe <= 1'b0;
      r_scan_clk    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_fetch_req   <= (w_next == FETCH);
      r_exec_en     <= (w_next == EXEC);
      r_in_latch    <= (w_next == LATCH);
      r_out_commit  <= (w_next == COMMIT);
      r_addr_strobe <= (w_next == FETCH) && (r_state != FETCH);
      r_scan_clk    <= r_scan_clk ^ (w_next == COMMIT);
      r_busy        <= (w_next != IDLE);
    end
  end

  assign o_fetch_req      = r_fetch_req;
  assign o_fetch_addr     = r_pc;
  assign o_instr          = r_instr;
  assign o_exec_en        = r_exec_en;
  assign o_in_latch       = r_in_latch;
  assign o_out_commit     = r_out_commit;
  assign o_addr_strobe    = r_addr_strobe;
  assign o_scan_cycle_clk = r_scan_clk;
  assign o_busy           = r_busy;
  assign o_fault          = w_fault;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Self-checking bench for vslc_scan_sequencer: randomized program memory and fetch waits against a scan-level model.
module tb_vslc_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       fetch_ack = 1'b0;
  logic [7:0] prog_last = 8'd0;
  logic [7:0] fetch_data = 8'd0;
  logic       fetch_req, exec_en, in_latch, out_commit, addr_strobe, scan_cycle_clk, busy, fault;
  logic [7:0] fetch_addr, instr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  bit ack_en = 1'b1;
  int wait_lo = 0, wait_hi = 0;
  int q_wait[$], q_addr[$], q_strobe_cyc[$], q_exec[$], q_latch_cyc[$], q_commit_cyc[$];
  int exp_addr[$], exp_exec[$];
  int cyc = 0, n_commits_rst = 0, n_req_cyc = 0, n_bad_strobe = 0, n_addr_moved = 0;

  always #5 clk = ~clk;

  vslc_scan_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_run            (run),
    .i_step           (step),
    .i_prog_last      (prog_last),
    .o_fetch_req      (fetch_req),
    .o_fetch_addr     (fetch_addr),
    .i_fetch_ack      (fetch_ack),
    .i_fetch_data     (fetch_data),
    .o_instr          (instr),
    .o_exec_en        (exec_en),
    .o_in_latch       (in_latch),
    .o_out_commit     (out_commit),
    .o_addr_strobe    (addr_strobe),
    .o_scan_cycle_clk (scan_cycle_clk),
    .o_busy           (busy),
    .o_fault          (fault)
  );

  // Program-memory responder: acks each request after a random number of wait cycles.
  bit in_req = 1'b0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    fetch_ack = 1'b0;
    if (!rst_n || !fetch_req) begin
      in_req = 1'b0;
    end else if (ack_en) begin
      if (!in_req) begin
        in_req = 1'b1;
        wait_cnt = $urandom_range(wait_hi, wait_lo);
        q_wait.push_back(wait_cnt);
      end
      if (wait_cnt == 0) begin
        fetch_ack = 1'b1;
        fetch_data = mem[fetch_addr];
        in_req = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  end

  // Event recorder.
  bit prev_req = 1'b0;
  logic [7:0] prev_addr = 8'd0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      n_commits_rst = 0;
      prev_req = 1'b0;
    end else begin
      if (addr_strobe) begin
        q_addr.push_back(int'(fetch_addr));
        q_strobe_cyc.push_back(cyc);
        if (!fetch_req || prev_req) n_bad_strobe++;
      end else if (fetch_req && !prev_req) begin
        n_bad_strobe++;
      end
      if (fetch_req && prev_req && fetch_addr != prev_addr) n_addr_moved++;
      if (fetch_req) n_req_cyc++;
      if (exec_en) q_exec.push_back(int'(instr));
      if (in_latch) q_latch_cyc.push_back(cyc);
      if (out_commit) begin
        q_commit_cyc.push_back(cyc);
        n_commits_rst++;
      end
      prev_req = fetch_req;
      prev_addr = fetch_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Scan-level reference: fetch 0..last in order, stop early at an END opcode (not executed).
  task automatic build_expect(input int last);
    for (int a = 0; a <= last; a++) begin
      exp_addr.push_back(a);
      if (mem[a] == 8'hFF) break;
      exp_exec.push_back(int'(mem[a]));
    end
  endtask

  function automatic int model_latency();
    int lat = 2 + exp_exec.size();
    foreach (q_wait[i]) lat += q_wait[i] + 1;
    return lat;
  endfunction

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_mon();
    q_wait.delete(); q_addr.delete(); q_strobe_cyc.delete(); q_exec.delete();
    q_latch_cyc.delete(); q_commit_cyc.delete(); exp_addr.delete(); exp_exec.delete();
    n_req_cyc = 0; n_bad_strobe = 0; n_addr_moved = 0;
  endtask

  task automatic fill_mem(input int last, input int end_pct);
    for (int a = 0; a <= last; a++)
      mem[a] = ($urandom_range(99, 0) < end_pct) ? 8'hFF : 8'($urandom_range(254, 0));
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    #1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, max_cyc); end
  endtask

  task automatic wait_commits(input int n, input int max_cyc, input string tag);
    int k = 0;
    for (int i = 0; i < max_cyc && k < n; i++) begin
      @(negedge clk);
      if (out_commit) k++;
    end
    n_cmp++;
    if (k < n) begin n_err++; $display("FAIL %s_commit_timeout: saw %0d commits, required %0d", tag, k, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fetch_req, exec_en, in_latch, out_commit, addr_strobe, scan_cycle_clk, busy, fault} !== 8'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, required 00000000",
                        {fetch_req, exec_en, in_latch, out_commit, addr_strobe, scan_cycle_clk, busy, fault});
    end
    n_cmp++;
    if (fetch_addr !== 8'd0 || instr !== 8'd0) begin
      n_err++; $display("FAIL reset_regs: addr=%h instr=%h, required 00/00", fetch_addr, instr);
    end
    rst_n = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || q_latch_cyc.size() != 0) begin
      n_err++; $display("FAIL reset_idle_hold: busy=%b latches=%0d, required 0/0", busy, q_latch_cyc.size());
    end
  endtask

  task automatic test_basic_scan();
    clear_mon(); prog_last = 8'd3; wait_lo = 1; wait_hi = 1;
    fill_mem(3, 0);
    build_expect(3); build_expect(3);
    @(negedge clk); run = 1'b1;
    wait_commits(2, 100, "basic");
    run = 1'b0;
    wait_idle(50, "basic");
    n_cmp++;
    if (!q_eq(q_addr, exp_addr)) begin n_err++; $display("FAIL basic_addrs: got %p, required %p", q_addr, exp_addr); end
    n_cmp++;
    if (!q_eq(q_exec, exp_exec)) begin n_err++; $display("FAIL basic_exec: got %p, required %p", q_exec, exp_exec); end
    n_cmp++;
    if (q_commit_cyc.size() != 2 || q_latch_cyc.size() != 2) begin
      n_err++; $display("FAIL basic_counts: commits=%0d latches=%0d, required 2/2", q_commit_cyc.size(), q_latch_cyc.size());
    end
    n_cmp++;
    if (q_latch_cyc.size() < 2 || q_commit_cyc.size() < 1 || q_latch_cyc[1] != q_commit_cyc[0] + 1) begin
      n_err++; $display("FAIL basic_no_gap: second latch not the cycle after first commit (%p / %p)", q_latch_cyc, q_commit_cyc);
    end
    n_cmp++;
    if (q_commit_cyc.size() < 1 || q_latch_cyc.size() < 1 || q_commit_cyc[0] - q_latch_cyc[0] + 1 != 14) begin
      n_err++; $display("FAIL basic_latency: latch=%p commit=%p, required 14 cycles", q_latch_cyc, q_commit_cyc);
    end
    n_cmp++;
    if (scan_cycle_clk !== 1'(n_commits_rst % 2)) begin
      n_err++; $display("FAIL basic_scan_clk: got %b, required %0d", scan_cycle_clk, n_commits_rst % 2);
    end
    n_cmp++;
    if (n_bad_strobe != 0 || n_addr_moved != 0) begin
      n_err++; $display("FAIL basic_handshake: bad_strobes=%0d addr_moves=%0d, required 0/0", n_bad_strobe, n_addr_moved);
    end
  endtask

  task automatic test_end_opcode();
    int last_s;
    clear_mon(); prog_last = 8'd7; wait_lo = 1; wait_hi = 1;
    fill_mem(7, 0);
    mem[2] = 8'hFF;
    build_expect(7);
    pulse_step();
    wait_idle(100, "end");
    n_cmp++;
    if (!q_eq(q_addr, exp_addr)) begin n_err++; $display("FAIL end_addrs: got %p, required %p", q_addr, exp_addr); end
    n_cmp++;
    if (q_exec.size() != 2 || !q_eq(q_exec, exp_exec)) begin n_err++; $display("FAIL end_exec: got %p, required %p", q_exec, exp_exec); end
    last_s = (q_strobe_cyc.size() > 0) ? q_strobe_cyc[q_strobe_cyc.size() - 1] : -100;
    n_cmp++;
    if (q_commit_cyc.size() != 1 || q_commit_cyc[0] != last_s + 2) begin
      n_err++; $display("FAIL end_commit: commits=%p, required one at cycle %0d", q_commit_cyc, last_s + 2);
    end
  endtask

  task automatic test_single_step();
    clear_mon(); prog_last = 8'($urandom_range(5, 1)); wait_lo = 0; wait_hi = 2;
    fill_mem(int'(prog_last), 0);
    build_expect(int'(prog_last));
    pulse_step();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL step_busy: got %b, required 1", busy); end
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_idle(100, "step");
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (q_latch_cyc.size() != 1 || q_commit_cyc.size() != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL step_once: latches=%0d commits=%0d busy=%b, required 1/1/0", q_latch_cyc.size(), q_commit_cyc.size(), busy);
    end
    n_cmp++;
    if (!q_eq(q_addr, exp_addr)) begin n_err++; $display("FAIL step_addrs: got %p, required %p", q_addr, exp_addr); end
    n_cmp++;
    if (q_commit_cyc.size() < 1 || q_commit_cyc[0] - q_latch_cyc[0] + 1 != model_latency()) begin
      n_err++; $display("FAIL step_latency: latch=%p commit=%p, required %0d cycles", q_latch_cyc, q_commit_cyc, model_latency());
    end
  endtask

  task automatic test_halt_mid_scan();
    bit hit = 1'b0;
    clear_mon(); prog_last = 8'd3; wait_lo = 1; wait_hi = 1;
    fill_mem(3, 0);
    build_expect(3);
    @(negedge clk); run = 1'b1;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = addr_strobe && fetch_addr == 8'd1;
    end
    run = 1'b0;
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL halt_strobe_timeout: addr 1 never requested, required it"); end
    wait_idle(50, "halt");
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (!q_eq(q_addr, exp_addr) || !q_eq(q_exec, exp_exec)) begin
      n_err++; $display("FAIL halt_complete: addrs=%p execs=%0d, required %p / %0d", q_addr, q_exec.size(), exp_addr, exp_exec.size());
    end
    n_cmp++;
    if (q_commit_cyc.size() != 1 || q_latch_cyc.size() != 1) begin
      n_err++; $display("FAIL halt_once: commits=%0d latches=%0d, required 1/1", q_commit_cyc.size(), q_latch_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    bit gap_ok = 1'b1;
    clear_mon(); prog_last = 8'd2; wait_lo = 0; wait_hi = 2;
    fill_mem(2, 0);
    @(negedge clk); run = 1'b1; step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_commits(3, 200, "b2b");
    run = 1'b0;
    wait_idle(50, "b2b");
    for (int i = 0; i + 1 < q_latch_cyc.size(); i++)
      if (i >= q_commit_cyc.size() || q_latch_cyc[i + 1] != q_commit_cyc[i] + 1) gap_ok = 1'b0;
    n_cmp++;
    if (q_latch_cyc.size() != 3 || q_commit_cyc.size() != 3 || !gap_ok) begin
      n_err++; $display("FAIL b2b_scans: latches=%p commits=%p, required 3 gapless scans", q_latch_cyc, q_commit_cyc);
    end
  endtask

  task automatic test_random_scans();
    int last;
    for (int it = 0; it < 10; it++) begin
      last = (it == 0) ? 0 : (it == 9) ? 255 : $urandom_range(20, 1);
      clear_mon(); prog_last = 8'(last);
      wait_lo = 0; wait_hi = (it == 9) ? 0 : 3;
      fill_mem(last, (it == 9) ? 0 : 12);
      build_expect(last);
      pulse_step();
      wait_idle(2000, "rand");
      n_cmp++;
      if (!q_eq(q_addr, exp_addr)) begin n_err++; $display("FAIL rand%0d_addrs: got %0d fetches, required %0d", it, q_addr.size(), exp_addr.size()); end
      n_cmp++;
      if (!q_eq(q_exec, exp_exec)) begin n_err++; $display("FAIL rand%0d_exec: got %0d execs, required %0d", it, q_exec.size(), exp_exec.size()); end
      n_cmp++;
      if (q_commit_cyc.size() != 1 || q_latch_cyc.size() != 1 || q_commit_cyc[0] - q_latch_cyc[0] + 1 != model_latency()) begin
        n_err++; $display("FAIL rand%0d_latency: latch=%p commit=%p, required one scan of %0d cycles", it, q_latch_cyc, q_commit_cyc, model_latency());
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    clear_mon(); ack_en = 1'b0; prog_last = 8'd3;
    fill_mem(3, 0);
    @(negedge clk); run = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (fetch_req !== 1'b1 || fault !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_fetch: fetch_req=%b fault=%b, required 1/0", fetch_req, fault);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fetch_req, exec_en, in_latch, out_commit, addr_strobe, scan_cycle_clk, busy, fault} !== 8'b0 ||
        fetch_addr !== 8'd0 || instr !== 8'd0) begin
      n_err++; $display("FAIL rst_async: flags=%b addr=%h instr=%h, required all zero",
                        {fetch_req, exec_en, in_latch, out_commit, addr_strobe, scan_cycle_clk, busy, fault}, fetch_addr, instr);
    end
    run = 1'b0; ack_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    clear_mon(); wait_lo = 0; wait_hi = 0;
    build_expect(3);
    @(negedge clk); run = 1'b1;
    wait_commits(1, 100, "rst_restart");
    run = 1'b0;
    wait_idle(50, "rst_restart");
    n_cmp++;
    if (!q_eq(q_addr, exp_addr) || q_commit_cyc.size() != 1 || scan_cycle_clk !== 1'b1) begin
      n_err++; $display("FAIL rst_restart: addrs=%p commits=%0d scan_clk=%b, required %p / 1 / 1",
                        q_addr, q_commit_cyc.size(), scan_cycle_clk, exp_addr);
    end
  endtask

`ifdef VSLC_SCAN_WATCHDOG_EN
  task automatic test_watchdog();
    clear_mon(); ack_en = 1'b0; prog_last = 8'd3;
    @(negedge clk); run = 1'b1;
    wait_idle(300, "wdt");
    n_cmp++;
    if (n_req_cyc != 64 || fault !== 1'b1) begin
      n_err++; $display("FAIL wdt_timeout: req_cycles=%0d fault=%b, required 64/1", n_req_cyc, fault);
    end
    n_cmp++;
    if (q_commit_cyc.size() != 0) begin n_err++; $display("FAIL wdt_no_commit: commits=%0d, required 0", q_commit_cyc.size()); end
    pulse_step();
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (q_latch_cyc.size() != 1 || busy !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL wdt_sticky: latches=%0d busy=%b fault=%b, required 1/0/1", q_latch_cyc.size(), busy, fault);
    end
    run = 1'b0; ack_en = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL wdt_reset_clear: fault=%b, required 0", fault); end
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'd0;
    test_reset();
    test_basic_scan();
    test_end_opcode();
    test_single_step();
    test_halt_mid_scan();
    test_back_to_back();
    test_random_scans();
    test_reset_mid_fetch();
`ifdef VSLC_SCAN_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
